// File: rtl/main_ctl_pkg.sv
// Shared types for the multicycle main control: state encodings, opcodes,
// ALUOp codes and the control word handed from the output decoder to the top.
// ILLEGAL_TRAP_EN selects whether illegal opcodes trap or run as a NOP.
package main_ctl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        TRAP      = 4'd11,
        ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       trap;
    } ctl_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Controller <-> datapath bundle: IR opcode and memory ready in, control
// word out. master = controller side, slave = datapath side.
interface multicycle_main_control_if #(
    parameter int OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic [1:0]          alu_op;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                pc_write;
    logic                pc_write_cond;
    logic [1:0]          pc_source;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;

    modport master (
        input  opcode, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond,
               pc_source, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write
    );

    modport slave (
        output opcode, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond,
               pc_source, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write
    );
endinterface

// File: rtl/main_ctl_outdec.sv
// Purely combinational state -> control word decoder (Moore outputs).
// TRAP only drives trap=1 when ILLEGAL_TRAP_EN is defined.
import main_ctl_pkg::*;

module main_ctl_outdec (
    input  state_t state,
    input  logic   mem_ready,
    output ctl_t   ctl
);
    // decode the control word for the current state; unlisted fields stay 0
    always_comb begin
        ctl = '0;
        case (state)
            FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.alu_op    = ALUOP_ADD;
                // PC/IR update only on the completing cycle so stalls are harmless
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctl.alu_src_b = 2'b11;
                ctl.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR, ADDI_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
            end
            MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
            end
            R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = 2'b01;
            end
            JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = 2'b10;
            end
            ADDI_WB: begin
                ctl.reg_write = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: ctl.trap = 1'b1;
`endif
            default: ctl = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle main-control FSM: fetch/decode/execute/memory/writeback
// sequencing, stalling on mem_ready. Reset forces all outputs low at once.
// ILLEGAL_TRAP_EN: illegal opcodes go to a sticky TRAP state instead of FETCH.
import main_ctl_pkg::*;

module multicycle_main_control #(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    multicycle_main_control_if.master    bus,
    output logic [STATE_W-1:0]           state_o,
    output logic                         trap
);
    state_t state;
    ctl_t   dec, ctl;

    function automatic logic is_op(input logic [OPCODE_W-1:0] op, input logic [5:0] ref_op);
        return op == OPCODE_W'(ref_op);
    endfunction

    // state register with next-state selection by state/opcode/mem_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:     state <= bus.mem_ready ? DECODE : FETCH;
                DECODE: begin
                    if (is_op(bus.opcode, OP_LW) || is_op(bus.opcode, OP_SW)) state <= MEM_ADDR;
                    else if (is_op(bus.opcode, OP_RTYPE)) state <= R_EXEC;
                    else if (is_op(bus.opcode, OP_BEQ))   state <= BRANCH;
                    else if (is_op(bus.opcode, OP_J))     state <= JUMP;
                    else if (is_op(bus.opcode, OP_ADDI))  state <= ADDI_EXEC;
`ifdef ILLEGAL_TRAP_EN
                    else                                  state <= TRAP;
`else
                    else                                  state <= FETCH;
`endif
                end
                MEM_ADDR: begin
                    if (is_op(bus.opcode, OP_LW))      state <= MEM_READ;
                    else if (is_op(bus.opcode, OP_SW)) state <= MEM_WRITE;
                    else                               state <= FETCH;
                end
                MEM_READ:  state <= bus.mem_ready ? MEM_WB : MEM_READ;
                MEM_WB:    state <= FETCH;
                MEM_WRITE: state <= bus.mem_ready ? FETCH : MEM_WRITE;
                R_EXEC:    state <= R_WB;
                R_WB:      state <= FETCH;
                BRANCH:    state <= FETCH;
                JUMP:      state <= FETCH;
                ADDI_EXEC: state <= ADDI_WB;
                ADDI_WB:   state <= FETCH;
`ifdef ILLEGAL_TRAP_EN
                TRAP:      state <= TRAP;
`endif
                default:   state <= FETCH;
            endcase
        end
    end

    main_ctl_outdec u_outdec (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .ctl       (dec)
    );

    // reset masks the decoded word so pending memory requests drop immediately
    always_comb begin
        ctl = rst ? '0 : dec;
    end

    assign bus.alu_op        = ctl.alu_op;
    assign bus.alu_src_a     = ctl.alu_src_a;
    assign bus.alu_src_b     = ctl.alu_src_b;
    assign bus.pc_write      = ctl.pc_write;
    assign bus.pc_write_cond = ctl.pc_write_cond;
    assign bus.pc_source     = ctl.pc_source;
    assign bus.i_or_d        = ctl.i_or_d;
    assign bus.mem_read      = ctl.mem_read;
    assign bus.mem_write     = ctl.mem_write;
    assign bus.ir_write      = ctl.ir_write;
    assign bus.reg_dst       = ctl.reg_dst;
    assign bus.mem_to_reg    = ctl.mem_to_reg;
    assign bus.reg_write     = ctl.reg_write;
    assign trap              = ctl.trap;
    assign state_o           = rst ? STATE_W'(FETCH) : STATE_W'(state);

endmodule
